// File: rtl/if_fetch_queue.sv
// Instruction fetch unit: PC generation, one-cycle ROM read handshake and a DEPTH-entry
// fetch queue feeding ID. Defining IF_PERF_CNT_EN adds pop and stall performance counters.
module if_fetch_queue #(
    parameter int                ADDR_W   = 32,
    parameter int                INST_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h1c00_0000
) (
    input  logic              clk,
    input  logic              rst,
    output logic              inst_ce_o,
    output logic [ADDR_W-1:0] inst_addr_o,
    input  logic [INST_W-1:0] rom_data_i,
    input  logic              br_taken_i,
    input  logic [ADDR_W-1:0] br_target_i,
    output logic              id_valid_o,
    output logic [ADDR_W-1:0] id_pc_o,
    output logic [INST_W-1:0] id_inst_o,
    input  logic              id_ready_i
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]       fetch_cnt_o,
    output logic [31:0]       stall_cnt_o
`endif
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int OCC_W = CNT_W + 1;
    localparam logic [OCC_W-1:0]  DEPTH_C  = OCC_W'(DEPTH);
    localparam logic [CNT_W-1:0]  CNT_ZERO = CNT_W'(1'b0);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1'b1);
    localparam logic [PTR_W-1:0]  PTR_ZERO = PTR_W'(1'b0);
    localparam logic [PTR_W-1:0]  PTR_ONE  = PTR_W'(1'b1);
    localparam logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(3'd4);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic              infl_q, infl_d;
    logic [ADDR_W-1:0] infl_pc_q, infl_pc_d;
    logic [ADDR_W-1:0] pc_mem_q   [DEPTH];
    logic [INST_W-1:0] inst_mem_q [DEPTH];

    logic [OCC_W-1:0]  occ_s;
    logic              issue_s;
    logic              push_s;
    logic              pop_s;
    logic              not_empty_s;
    logic              tgt_lsb_unused_s;

    // Target is forced word aligned, so its two low bits never matter.
    assign tgt_lsb_unused_s = ^br_target_i[1:0];
    assign not_empty_s      = (count_q != CNT_ZERO);

    // Qualify issue/push/pop; a redirect or reset suppresses all three.
    always_comb begin
        occ_s   = {1'b0, count_q} + OCC_W'(infl_q);
        issue_s = 1'b0;
        push_s  = 1'b0;
        pop_s   = 1'b0;
        if (rst && !br_taken_i) begin
            issue_s = (occ_s < DEPTH_C);
            push_s  = infl_q;
            pop_s   = not_empty_s && id_ready_i;
        end else begin
            issue_s = 1'b0;
            push_s  = 1'b0;
            pop_s   = 1'b0;
        end
    end

    assign inst_ce_o   = issue_s;
    assign inst_addr_o = pc_q;
    assign id_valid_o  = rst && not_empty_s;
    assign id_pc_o     = rst ? pc_mem_q[rd_ptr_q]   : {ADDR_W{1'b0}};
    assign id_inst_o   = rst ? inst_mem_q[rd_ptr_q] : {INST_W{1'b0}};

    // Next-state: redirect flushes queue and in-flight slot, otherwise normal issue/push/pop.
    always_comb begin
        pc_d      = pc_q;
        count_d   = count_q;
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        infl_d    = infl_q;
        infl_pc_d = infl_pc_q;
        if (br_taken_i) begin
            pc_d     = {br_target_i[ADDR_W-1:2], 2'b00};
            count_d  = CNT_ZERO;
            rd_ptr_d = wr_ptr_q;
            infl_d   = 1'b0;
        end else begin
            infl_d = issue_s;
            if (issue_s) begin
                pc_d      = pc_q + PC_STEP;
                infl_pc_d = pc_q;
            end else begin
                pc_d      = pc_q;
                infl_pc_d = infl_pc_q;
            end
            if (push_s) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    // Control state registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_q      <= RESET_PC;
            count_q   <= CNT_ZERO;
            rd_ptr_q  <= PTR_ZERO;
            wr_ptr_q  <= PTR_ZERO;
            infl_q    <= 1'b0;
            infl_pc_q <= {ADDR_W{1'b0}};
        end else begin
            pc_q      <= pc_d;
            count_q   <= count_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            infl_q    <= infl_d;
            infl_pc_q <= infl_pc_d;
        end
    end

    // Queue storage; contents are only observable through the gated head outputs.
    always_ff @(posedge clk) begin
        if (push_s) begin
            pc_mem_q[wr_ptr_q]   <= infl_pc_q;
            inst_mem_q[wr_ptr_q] <= rom_data_i;
        end
    end

`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_cnt_q;
    logic [31:0] stall_cnt_q;

    // Delivered-instruction and back-pressure counters, wrapping at 2^32.
    always_ff @(posedge clk) begin
        if (!rst) begin
            fetch_cnt_q <= 32'd0;
            stall_cnt_q <= 32'd0;
        end else begin
            if (pop_s) begin
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            end
            if (id_valid_o && !id_ready_i) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

    assign fetch_cnt_o = fetch_cnt_q;
    assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: doc/if_fetch_queue.md
IF_FETCH_QUEUE -- requirements
Module: if_fetch_queue

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, PC/instruction address width.
REQ-002 SHALL have parameter INST_W, default 32, instruction word width.
REQ-003 SHALL have parameter DEPTH, default 4, fetch queue entries; a power of two, at least 2.
REQ-004 SHALL have parameter RESET_PC, default 32'h1c000000, first fetch address after reset.
REQ-005 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-006 SHALL have port rst, input, 1, reset; synchronous and active-low.
REQ-007 SHALL have port inst_ce_o, output, 1, ROM read enable; a fetch is issued this cycle.
REQ-008 SHALL have port inst_addr_o, output, ADDR_W, ROM read address.
REQ-009 SHALL have port rom_data_i, input, INST_W, ROM data, valid exactly one cycle after inst_ce_o.
REQ-010 SHALL have port br_taken_i, input, 1, redirect request from ID/EX.
REQ-011 SHALL have port br_target_i, input, ADDR_W, redirect address.
REQ-012 SHALL have ports id_valid_o (output, 1), id_pc_o (output, ADDR_W) and id_inst_o (output, INST_W); these form the head entry offered to ID.
REQ-013 SHALL have port id_ready_i, input, 1, ID accepts the head entry.

Function
REQ-014 SHALL keep a fetch PC register pc_r; inst_addr_o = pc_r at all times.
REQ-015 SHALL assert inst_ce_o when rst high, br_taken_i low and (count + inflight) < DEPTH, where inflight = fetch issued in the previous cycle and not yet returned.
REQ-016 SHALL advance pc_r by 4 (modulo 2^ADDR_W, wrapping) in each cycle inst_ce_o is high.
REQ-017 SHALL, one cycle after an issue, push {issued PC, rom_data_i} into the queue tail; the issued PC is held in a one-entry in-flight register.
REQ-018 SHALL drive id_valid_o = queue not empty, with id_pc_o/id_inst_o = head entry; it SHALL pop the head when id_valid_o and id_ready_i are both high.
REQ-019 SHALL support push and pop in the same cycle, in which case count is unchanged; the issue rule guarantees no push ever occurs into a full queue.
REQ-020 SHALL, in a cycle with br_taken_i high, load pc_r with {br_target_i[ADDR_W-1:2], 2'b00}, empty the queue, discard any in-flight return, ignore id_ready_i and issue no fetch; fetching resumes at the target on the next cycle.
REQ-021 SHALL give br_taken_i priority over push, pop and issue when they coincide.
REQ-022 SHALL present id_valid_o low in the cycle after a redirect; the first target instruction is offered no earlier than 2 cycles after the redirect cycle.
REQ-023 SHALL hold id_pc_o/id_inst_o stable while id_valid_o is high and id_ready_i is low.
REQ-024 SHALL sustain one instruction per cycle with id_ready_i held high after the pipeline fills.

Reset
REQ-025 SHALL, on a clock edge with rst low, set pc_r = RESET_PC, count = 0, inflight = 0, and queue pointers = 0.
REQ-026 SHALL hold inst_ce_o = 0 and id_valid_o = 0 while rst is low; id_pc_o/id_inst_o SHALL read 0.
REQ-027 SHALL, when rst is asserted mid-operation, discard any in-flight return; the first issue after rst deassertion SHALL be at RESET_PC.

Configuration
REQ-028 SHALL use macro IF_PERF_CNT_EN: when defined, add output ports fetch_cnt_o and stall_cnt_o, each 32 bits and reset to 0.
REQ-029 SHALL, with IF_PERF_CNT_EN defined, increment fetch_cnt_o on each pop and stall_cnt_o on each cycle with id_valid_o high and id_ready_i low, both wrapping at 2^32.
REQ-030 SHALL, without IF_PERF_CNT_EN, omit these ports and counters entirely; all other behaviour is identical.

Verification
REQ-031 SHALL cover reset release with id_ready_i=1 and a ROM returning its address: inst_addr_o sequence 1c000000, 1c000004, 1c000008...; id_valid_o first high on cycle 2; one pop per cycle thereafter.
REQ-032 SHALL cover id_ready_i=0 for 10 cycles with DEPTH=4: exactly 4 entries are buffered, inst_ce_o drops, and after release pops are in order with no loss or duplicate.
REQ-033 SHALL cover br_taken_i=1, br_target_i=1c000103 with the queue at 3 entries: the queue empties, the next issue is at 1c000100, and the first id_pc_o after the redirect is 1c000100.
REQ-034 SHALL cover a redirect coinciding with a pop and an in-flight return: the popped and returned entries are dropped, and count is 0 on the next cycle.
REQ-035 SHALL cover rst low for 1 cycle mid-stream: the next issue is at 1c000000, and a stale rom_data_i is never pushed.
REQ-036 SHALL cover IF_PERF_CNT_EN with 20 pops and 5 stall cycles: fetch_cnt_o=20, stall_cnt_o=5.
